// File: rtl/mem_load_stage.sv
// Memory/load pipeline stage: waits for data responses and aligns load data for writeback.
// Tracks responses still owed to flushed loads so that they never reach a later instruction.
module mem_load_stage #(
  parameter int unsigned CANCEL_MAX = 2,
  parameter logic [31:0] RESET_PC   = 32'hbfc00000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        es_to_ms_valid,
  output logic        ms_allowin,
  input  logic [31:0] es_pc,
  input  logic [31:0] es_alu_result,
  input  logic [31:0] es_rt_value,
  input  logic [4:0]  es_dest,
  input  logic        es_gr_we,
  input  logic        es_mem_req,
  input  logic [6:0]  es_load_op,
  input  logic        data_ok,
  input  logic [31:0] data_rdata,
  input  logic        ws_allowin,
  output logic        ms_to_ws_valid,
  output logic [31:0] ms_pc,
  output logic [4:0]  ms_dest,
  output logic        ms_gr_we,
  output logic [31:0] ms_result,
  output logic        ms_fwd_valid,
  output logic        ms_load_pending
);

  localparam logic [2:0] CancelMax = 3'(CANCEL_MAX);

  // One-hot load opcode bit positions: {lw,lb,lbu,lh,lhu,lwl,lwr}
  localparam int unsigned OpLw  = 6;
  localparam int unsigned OpLb  = 5;
  localparam int unsigned OpLbu = 4;
  localparam int unsigned OpLh  = 3;
  localparam int unsigned OpLhu = 2;
  localparam int unsigned OpLwl = 1;
  localparam int unsigned OpLwr = 0;

  logic        ms_valid;
  logic [31:0] ms_alu_result;
  logic [31:0] ms_rt_value;
  logic        mem_req_r;
  logic [6:0]  load_op_r;
  logic        buf_valid;
  logic [31:0] buf_data;
  logic [2:0]  cancel_cnt;
  logic [2:0]  cancel_cnt_d;

  logic        cancel_zero;
  logic        has_data;
  logic        ms_ready_go;
  logic        buf_capture;
  logic        cnt_inc;
  logic        cnt_dec;

  assign cancel_zero     = (cancel_cnt == 3'd0);
  assign has_data        = buf_valid | (data_ok & cancel_zero);
  assign ms_ready_go     = ~mem_req_r | has_data;
  // Reset gating keeps handshake outputs defined before the first reset edge.
  assign ms_allowin      = reset |
                           ((~ms_valid | (ms_ready_go & ws_allowin)) & (cancel_cnt != CancelMax));
  assign ms_to_ws_valid  = ~reset & ms_valid & ms_ready_go & ~flush;
  assign ms_fwd_valid    = ~reset & ms_valid & ms_ready_go;
  assign ms_load_pending = ~reset & ms_valid & mem_req_r & ~has_data;

  assign buf_capture = ms_valid & mem_req_r & ~buf_valid & data_ok & cancel_zero &
                       ~ws_allowin & ~flush;

  assign cnt_dec = data_ok & ~cancel_zero;
  assign cnt_inc = flush & ms_valid & mem_req_r & ~has_data;

  always_comb begin
    cancel_cnt_d = cancel_cnt;
    if (cnt_dec) cancel_cnt_d = cancel_cnt_d - 3'd1;
    if (cnt_inc && cancel_cnt_d != CancelMax) cancel_cnt_d = cancel_cnt_d + 3'd1;
  end

  // Load data alignment
  logic [31:0] rd;
  logic [31:0] rd_shr;
  logic [15:0] rd_half;
  logic [5:0]  sh_k;
  logic [5:0]  sh_lwl;
  logic [31:0] mask_lwl;
  logic [31:0] mask_lwr;
  logic [31:0] load_res;

  always_comb begin
    rd       = buf_valid ? buf_data : data_rdata;
    sh_k     = {1'b0, ms_alu_result[1:0], 3'b000};
    sh_lwl   = 6'd24 - sh_k;
    rd_shr   = rd >> sh_k;
    rd_half  = ms_alu_result[1] ? rd[31:16] : rd[15:0];
    // lwl keeps the rt bytes below the merged data; lwr keeps those above it.
    mask_lwl = 32'hffff_ffff >> (sh_k + 6'd8);
    mask_lwr = ~(32'hffff_ffff >> sh_k);
    load_res = 32'd0;
    unique case (1'b1)
      load_op_r[OpLw]:  load_res = rd;
      load_op_r[OpLb]:  load_res = {{24{rd_shr[7]}}, rd_shr[7:0]};
      load_op_r[OpLbu]: load_res = {24'd0, rd_shr[7:0]};
      load_op_r[OpLh]:  load_res = ms_alu_result[0] ? 32'd0 : {{16{rd_half[15]}}, rd_half};
      load_op_r[OpLhu]: load_res = ms_alu_result[0] ? 32'd0 : {16'd0, rd_half};
      load_op_r[OpLwl]: load_res = (rd << sh_lwl) | (ms_rt_value & mask_lwl);
      load_op_r[OpLwr]: load_res = rd_shr | (ms_rt_value & mask_lwr);
      default:          load_res = 32'd0;
    endcase
    ms_result = (|load_op_r) ? load_res : ms_alu_result;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid      <= 1'b0;
      ms_pc         <= RESET_PC;
      ms_alu_result <= 32'd0;
      ms_rt_value   <= 32'd0;
      ms_dest       <= 5'd0;
      ms_gr_we      <= 1'b0;
      mem_req_r     <= 1'b0;
      load_op_r     <= 7'd0;
      buf_valid     <= 1'b0;
      buf_data      <= 32'd0;
      cancel_cnt    <= 3'd0;
    end else begin
      if (flush) begin
        ms_valid <= 1'b0;
      end else if (ms_allowin) begin
        ms_valid <= es_to_ms_valid;
      end
      if (es_to_ms_valid && ms_allowin) begin
        ms_pc         <= es_pc;
        ms_alu_result <= es_alu_result;
        ms_rt_value   <= es_rt_value;
        ms_dest       <= es_dest;
        ms_gr_we      <= es_gr_we;
        mem_req_r     <= es_mem_req;
        load_op_r     <= es_load_op;
      end
      if (flush || (ms_to_ws_valid && ws_allowin)) begin
        buf_valid <= 1'b0;
      end else if (buf_capture) begin
        buf_valid <= 1'b1;
        buf_data  <= data_rdata;
      end
      cancel_cnt <= cancel_cnt_d;
    end
  end

endmodule
